// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// fetch FSM states and instruction size.
package ifu_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JMP  = 2'b10,
        PC_HALT = 2'b11
    } pc_src_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } ifu_state_t;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection: sequential, word-offset branch, or
// pseudo-direct jump. All arithmetic wraps modulo 2^32.
module ifu_next_pc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [15:0] immediate,
    input  logic [25:0] jump_addr,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;

    assign pc_plus4  = pc + 32'(INSTR_BYTES);
    assign br_offset = {{14{immediate[15]}}, immediate, 2'b00};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src_t'(pc_src))
            PC_SEQ:  next_pc = pc_plus4;
            PC_BR:   next_pc = pc_plus4 + br_offset;
            PC_JMP:  next_pc = {pc_plus4[31:28], jump_addr, 2'b00};
            PC_HALT: next_pc = pc;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, read strobe/latency FSM and issue
// handshake. Optional fetch counter enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          RD_LAT   = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] Immediate,
    input  logic [25:0] JumpAddr,
    output logic [31:0] IAddr,
    output logic        RW,
    output logic        InsValid,
    output logic        Halted
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] FetchCnt
`endif
);

    // WAIT spans RD_LAT-1 cycles; the counter is loaded with one less
    // because the cycle it reaches zero is itself the last WAIT cycle.
    localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    ifu_state_t  state;
    ifu_state_t  state_next;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [2:0]  lat_cnt;
    logic        pc_load;

    ifu_next_pc u_next_pc (
        .pc        (pc),
        .pc_src    (PCSrc),
        .immediate (Immediate),
        .jump_addr (JumpAddr),
        .next_pc   (next_pc)
    );

    // A halt request leaves the PC pointing at the halting instruction.
    assign pc_load = (state == ISSUE) && PCWre && (PCSrc != PC_HALT);
    assign IAddr   = pc;

    always_comb begin
        state_next = state;
        RW         = 1'b0;
        InsValid   = 1'b0;
        Halted     = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                RW         = 1'b1;
                state_next = (RD_LAT == 1) ? ISSUE : WAIT;
            end
            WAIT:  if (lat_cnt == 3'd0) state_next = ISSUE;
            ISSUE: begin
                InsValid = 1'b1;
                if (PCWre) state_next = (PCSrc == PC_HALT) ? HALT : FETCH;
            end
            HALT:  Halted = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            lat_cnt <= 3'd0;
        end else begin
            state <= state_next;
            if (pc_load) pc <= next_pc;
            if (state == FETCH)
                lat_cnt <= WAIT_INIT;
            else if ((state == WAIT) && (lat_cnt != 3'd0))
                lat_cnt <= lat_cnt - 3'd1;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!Reset)
            FetchCnt <= 32'd0;
        else if (state == FETCH)
            FetchCnt <= FetchCnt + 32'd1;
    end
`else
    // Counter omitted: no extra port or state in the default build.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: four instances cover RD_LAT 1/2/3
// and non-zero RESET_PC values; each is exercised in turn while the others sit in reset.
module tb_instruction_fetch_unit;

    logic        clk;
    logic [3:0]  rst_n_v;
    logic        pcwre;
    logic [1:0]  pcsrc;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] iaddr [4];
    logic [3:0]  rw;
    logic [3:0]  iv;
    logic [3:0]  halted;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fcnt [4];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // 0: RD_LAT=1 RESET_PC=0, 1: RD_LAT=3, 2: jump region, 3: wrap
    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .RD_LAT(1)) u_dut_lat1 (
        .CLK(clk), .Reset(rst_n_v[0]), .PCWre(pcwre), .PCSrc(pcsrc),
        .Immediate(imm), .JumpAddr(jaddr), .IAddr(iaddr[0]), .RW(rw[0]),
        .InsValid(iv[0]), .Halted(halted[0])
`ifdef IFU_PERF_CNT_EN
        , .FetchCnt(fcnt[0])
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .RD_LAT(3)) u_dut_lat3 (
        .CLK(clk), .Reset(rst_n_v[1]), .PCWre(pcwre), .PCSrc(pcsrc),
        .Immediate(imm), .JumpAddr(jaddr), .IAddr(iaddr[1]), .RW(rw[1]),
        .InsValid(iv[1]), .Halted(halted[1])
`ifdef IFU_PERF_CNT_EN
        , .FetchCnt(fcnt[1])
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'h1000_0004), .RD_LAT(2)) u_dut_jump (
        .CLK(clk), .Reset(rst_n_v[2]), .PCWre(pcwre), .PCSrc(pcsrc),
        .Immediate(imm), .JumpAddr(jaddr), .IAddr(iaddr[2]), .RW(rw[2]),
        .InsValid(iv[2]), .Halted(halted[2])
`ifdef IFU_PERF_CNT_EN
        , .FetchCnt(fcnt[2])
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .RD_LAT(1)) u_dut_wrap (
        .CLK(clk), .Reset(rst_n_v[3]), .PCWre(pcwre), .PCSrc(pcsrc),
        .Immediate(imm), .JumpAddr(jaddr), .IAddr(iaddr[3]), .RW(rw[3]),
        .InsValid(iv[3]), .Halted(halted[3])
`ifdef IFU_PERF_CNT_EN
        , .FetchCnt(fcnt[3])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic expect_out(input int d, input string tag, input logic [31:0] a,
                              input logic r, input logic v, input logic h);
        check({tag, ".iaddr"},    iaddr[d],  a);
        check({tag, ".rw"},       32'(rw[d]),     32'(r));
        check({tag, ".insvalid"}, 32'(iv[d]),     32'(v));
        check({tag, ".halted"},   32'(halted[d]), 32'(h));
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic rw_seen;

    initial begin
        clk     = 1'b0;
        rst_n_v = 4'b0000;
        pcwre   = 1'b0;
        pcsrc   = 2'b00;
        imm     = 16'h0000;
        jaddr   = 26'h0;
        repeat (3) tick();
        expect_out(0, "reset", 32'h0, 1'b0, 1'b0, 1'b0);
        check("reset_wrap_iaddr", iaddr[3], 32'hFFFF_FFFC);
`ifdef IFU_PERF_CNT_EN
        check("reset_fcnt", fcnt[0], 32'd0);
`endif

        // RD_LAT=1: start-up, sequential, branch, stall, halt
        rst_n_v[0] = 1'b1;
        tick(); expect_out(0, "start_fetch", 32'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(0, "start_issue", 32'h0, 1'b0, 1'b1, 1'b0);
        pcwre = 1'b1; pcsrc = 2'b00;
        tick(); expect_out(0, "seq_fetch4", 32'h4, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(0, "seq_issue4", 32'h4, 1'b0, 1'b1, 1'b0);
        tick(); expect_out(0, "seq_fetch8", 32'h8, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(0, "seq_issue8", 32'h8, 1'b0, 1'b1, 1'b0);
        pcsrc = 2'b01; imm = 16'hFFFE;
        tick(); expect_out(0, "br_back", 32'h4, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(0, "br_back_issue", 32'h4, 1'b0, 1'b1, 1'b0);
        imm = 16'h0003;
        tick(); expect_out(0, "br_fwd", 32'h14, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(0, "br_fwd_issue", 32'h14, 1'b0, 1'b1, 1'b0);
        pcwre = 1'b0; pcsrc = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick(); expect_out(0, $sformatf("stall%0d", i), 32'h14, 1'b0, 1'b1, 1'b0);
        end
        pcwre = 1'b1;
        tick(); expect_out(0, "halt", 32'h14, 1'b0, 1'b0, 1'b1);
        pcsrc   = 2'b00;
        rw_seen = 1'b0;
        repeat (10) begin
            tick();
            rw_seen = rw_seen | rw[0];
        end
        check("halt_no_rw", 32'(rw_seen), 32'd0);
        expect_out(0, "halt_hold", 32'h14, 1'b0, 1'b0, 1'b1);
        rst_n_v[0] = 1'b0;
        tick(); expect_out(0, "halt_reset", 32'h0, 1'b0, 1'b0, 1'b0);

        // RD_LAT=3: latency, reset during WAIT
        pcwre = 1'b0; pcsrc = 2'b00;
        rst_n_v[1] = 1'b1;
        tick(); expect_out(1, "l3_fetch", 32'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(1, "l3_wait1", 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check("l3_fcnt1", fcnt[1], 32'd1);
`endif
        tick(); expect_out(1, "l3_wait2", 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); expect_out(1, "l3_issue", 32'h0, 1'b0, 1'b1, 1'b0);
        pcwre = 1'b1;
        tick(); expect_out(1, "l3_fetch2", 32'h4, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(1, "l3_wait_b", 32'h4, 1'b0, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check("l3_fcnt2", fcnt[1], 32'd2);
`endif
        rst_n_v[1] = 1'b0;
        tick(); expect_out(1, "l3_rst_wait", 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check("l3_fcnt_rst", fcnt[1], 32'd0);
`endif
        tick(); expect_out(1, "l3_rst_hold", 32'h0, 1'b0, 1'b0, 1'b0);
        pcwre = 1'b0;
        rst_n_v[1] = 1'b1;
        tick(); expect_out(1, "l3_refetch", 32'h0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(1, "l3_rewait", 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check("l3_fcnt_restart", fcnt[1], 32'd1);
`endif
        rst_n_v[1] = 1'b0;

        // Jump from PC=0x1000_0004 (RD_LAT=2)
        pcwre = 1'b0;
        rst_n_v[2] = 1'b1;
        tick(); expect_out(2, "jmp_fetch", 32'h1000_0004, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(2, "jmp_wait", 32'h1000_0004, 1'b0, 1'b0, 1'b0);
        tick(); expect_out(2, "jmp_issue", 32'h1000_0004, 1'b0, 1'b1, 1'b0);
        pcwre = 1'b1; pcsrc = 2'b10; jaddr = 26'h000_0040;
        tick(); expect_out(2, "jmp_target", 32'h1000_0100, 1'b1, 1'b0, 1'b0);
        rst_n_v[2] = 1'b0;

        // Sequential wrap from 0xFFFF_FFFC
        pcwre = 1'b0; pcsrc = 2'b00;
        rst_n_v[3] = 1'b1;
        tick(); expect_out(3, "wrap_fetch", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        tick(); expect_out(3, "wrap_issue", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        pcwre = 1'b1;
        tick(); expect_out(3, "wrap_seq", 32'h0, 1'b1, 1'b0, 1'b0);
        rst_n_v[3] = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
